// File: rtl/panel_image_loader_pkg.sv
// Shared types and defaults for the front-panel image loader.
// Holds the loader state encoding, button select, image word layout and default timing.
package panel_image_loader_pkg;

  localparam logic [11:0] DEFAULT_START_PC      = 12'o0200;
  localparam int          DEFAULT_HOLD_CYCLES   = 10;
  localparam int          DEFAULT_SETTLE_CYCLES = 30;

  typedef enum logic [3:0] {
    S_IDLE, S_POP, S_LPC, S_DEP, S_EXM, S_SETTLE, S_CHECK, S_START_LPC, S_RUN
  } loader_state_t;

  typedef enum logic [1:0] {BTN_LPC, BTN_DEP, BTN_EXM} panel_btn_t;

  typedef struct packed {
    logic        last;
    logic [11:0] addr;
    logic [11:0] data;
  } image_word_t;

endpackage

// File: rtl/panel_image_loader_if.sv
// Inbound memory-image word stream: valid/ready handshake carrying {addr, data, last}.
// The source is the master; the loader FIFO is the slave and owns in_ready.
interface panel_image_loader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  modport master (output in_valid, in_addr, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_addr, in_data, in_last, output in_ready);
endinterface

// File: rtl/panel_image_loader_press_seq.sv
// One front-panel press: SET (switches driven), PRESS (button high), REL, HOLD_CYCLES each.
// Requests are accepted only while idle; o_done pulses on the final REL cycle.
module panel_press_seq
  import panel_image_loader_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              i_req,
  input  panel_btn_t        i_btn,
  input  logic [DATA_W-1:0] i_value,
  output logic [DATA_W-1:0] o_sw,
  output logic              o_lpc_btn,
  output logic              o_dep_btn,
  output logic              o_exm_btn,
  output logic              o_done,
  output logic              o_idle
);

  localparam int            CW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {PH_IDLE, PH_SET, PH_PRESS, PH_REL} phase_t;

  phase_t            r_phase, w_phase_nxt;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_sw;
  panel_btn_t        r_btn;
  logic              w_last;
  logic              w_press;

  assign w_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_phase <= PH_IDLE;
      r_cnt   <= '0;
      r_sw    <= '0;
      r_btn   <= BTN_LPC;
    end else begin
      r_phase <= w_phase_nxt;
      if (w_phase_nxt != r_phase) r_cnt <= '0;
      else if (r_phase != PH_IDLE) r_cnt <= r_cnt + 1'b1;
      // Switches only move on entry to SET, so they never toggle with a button edge.
      if (r_phase == PH_IDLE && i_req) begin
        r_sw  <= i_value;
        r_btn <= i_btn;
      end
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    o_done      = 1'b0;
    case (r_phase)
      PH_IDLE:  if (i_req)  w_phase_nxt = PH_SET;
      PH_SET:   if (w_last) w_phase_nxt = PH_PRESS;
      PH_PRESS: if (w_last) w_phase_nxt = PH_REL;
      PH_REL: begin
        if (w_last) begin
          w_phase_nxt = PH_IDLE;
          o_done      = 1'b1;
        end
      end
      default:  w_phase_nxt = PH_IDLE;
    endcase
  end

  assign w_press   = (r_phase == PH_PRESS);
  assign o_lpc_btn = w_press && (r_btn == BTN_LPC);
  assign o_dep_btn = w_press && (r_btn == BTN_DEP);
  assign o_exm_btn = w_press && (r_btn == BTN_EXM);
  assign o_sw      = r_sw;
  assign o_idle    = (r_phase == PH_IDLE);

endmodule

// File: rtl/panel_image_loader.sv
// Streams {addr,data,last} words from an inbound FIFO into Front_Panel Load PC/Deposit/Examine presses, then loads start_pc and runs.
// in_ready drops while the FIFO is full and permanently after the last word; each press takes 3*HOLD_CYCLES clocks.
module panel_image_loader
  import panel_image_loader_pkg::*;
#(
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 12,
  parameter int FIFO_DEPTH    = 8,
  parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int CNT_W         = 16
) (
  input  logic                 clock,
  input  logic                 resetN,
  panel_image_loader_if.slave  img,
  input  logic                 verify_en,
  input  logic [ADDR_W-1:0]    start_pc,
  input  logic [DATA_W-1:0]    panel_data,
  output logic [DATA_W-1:0]    sw_out,
  output logic                 load_pc_btn,
  output logic                 deposit_btn,
  output logic                 examine_btn,
  output logic                 run_sw,
  output logic                 busy,
  output logic                 load_done,
  output logic [CNT_W-1:0]     words_loaded,
  output logic [7:0]           mismatch_count,
  output logic [ADDR_W-1:0]    mismatch_addr
);

  localparam int            PW          = $clog2(FIFO_DEPTH);
  localparam int            SW          = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic              r_mem_last [FIFO_DEPTH];
  logic [PW:0]       r_wr_ptr, r_rd_ptr;
  logic              r_last_seen;
  logic              w_empty, w_full, w_in_ready, w_push;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_in_ready = !w_full && !r_last_seen;
  assign w_push     = img.in_valid && w_in_ready;
  assign img.in_ready = w_in_ready;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr[PW-1:0]] <= img.in_addr;
      r_mem_data[r_wr_ptr[PW-1:0]] <= img.in_data;
      r_mem_last[r_wr_ptr[PW-1:0]] <= img.in_last;
    end
  end

  loader_state_t     r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, r_exp_addr, r_mism_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_last, r_vfy, r_chk, r_exp_valid;
  logic [SW-1:0]     r_settle_cnt;
  logic [CNT_W-1:0]  r_words;
  logic [7:0]        r_mism_cnt;
  logic              w_settle_end, w_req, w_press_done, w_press_idle;
  panel_btn_t        w_btn;
  logic [DATA_W-1:0] w_value, w_press_sw;

  assign w_settle_end = (r_state == S_SETTLE) && (r_settle_cnt == SETTLE_LAST);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_last_seen  <= 1'b0;
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_data       <= '0;
      r_last       <= 1'b0;
      r_vfy        <= 1'b0;
      r_chk        <= 1'b0;
      r_exp_addr   <= '0;
      r_exp_valid  <= 1'b0;
      r_settle_cnt <= '0;
      r_words      <= '0;
      r_mism_cnt   <= '0;
      r_mism_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (img.in_last) r_last_seen <= 1'b1;
      end
      r_settle_cnt <= (r_state == S_SETTLE) ? r_settle_cnt + 1'b1 : '0;
      case (r_state)
        S_POP: begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_addr   <= r_mem_addr[r_rd_ptr[PW-1:0]];
          r_data   <= r_mem_data[r_rd_ptr[PW-1:0]];
          r_last   <= r_mem_last[r_rd_ptr[PW-1:0]];
          r_vfy    <= verify_en;
          r_chk    <= 1'b0;
        end
        S_DEP: begin
          if (w_press_done) begin
            r_exp_addr  <= r_addr + 1'b1;
            r_exp_valid <= 1'b1;
            r_words     <= r_words + 1'b1;
          end
        end
        // Examine advances the panel PC just as a deposit does.
        S_EXM: begin
          if (w_press_done) begin
            r_exp_addr  <= r_addr + 1'b1;
            r_exp_valid <= 1'b1;
          end
        end
        S_SETTLE: if (w_settle_end && !r_chk && r_vfy) r_chk <= 1'b1;
        S_CHECK: begin
          if (panel_data != r_data) begin
            if (r_mism_cnt == 8'd0) r_mism_addr <= r_addr;
            if (r_mism_cnt != 8'hFF) r_mism_cnt <= r_mism_cnt + 1'b1;
          end
        end
        S_START_LPC: if (w_press_done) r_exp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_btn       = BTN_LPC;
    w_value     = DATA_W'(r_addr);
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_nxt = S_POP;
        else if (r_last) w_state_nxt = S_START_LPC;
      end
      S_POP: begin
        if (r_exp_valid && r_mem_addr[r_rd_ptr[PW-1:0]] == r_exp_addr) w_state_nxt = S_DEP;
        else w_state_nxt = S_LPC;
      end
      S_LPC: begin
        w_req = w_press_idle;
        if (w_press_done) w_state_nxt = r_chk ? S_EXM : S_DEP;
      end
      S_DEP: begin
        w_req   = w_press_idle;
        w_btn   = BTN_DEP;
        w_value = r_data;
        if (w_press_done) w_state_nxt = S_SETTLE;
      end
      S_EXM: begin
        w_req = w_press_idle;
        w_btn = BTN_EXM;
        if (w_press_done) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (w_settle_end) begin
          if (r_chk) w_state_nxt = S_CHECK;
          else if (r_vfy) w_state_nxt = S_LPC;
          else if (r_last) w_state_nxt = S_START_LPC;
          else w_state_nxt = S_IDLE;
        end
      end
      S_CHECK: w_state_nxt = r_last ? S_START_LPC : S_IDLE;
      S_START_LPC: begin
        w_req   = w_press_idle;
        w_value = DATA_W'(start_pc);
        if (w_press_done) w_state_nxt = S_RUN;
      end
      S_RUN: w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  panel_press_seq #(
    .DATA_W      (DATA_W),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_press (
    .clock     (clock),
    .resetN    (resetN),
    .i_req     (w_req),
    .i_btn     (w_btn),
    .i_value   (w_value),
    .o_sw      (w_press_sw),
    .o_lpc_btn (load_pc_btn),
    .o_dep_btn (deposit_btn),
    .o_exm_btn (examine_btn),
    .o_done    (w_press_done),
    .o_idle    (w_press_idle)
  );

  assign sw_out         = (r_state == S_RUN) ? '0 : w_press_sw;
  assign run_sw         = (r_state == S_RUN);
  assign load_done      = (r_state == S_RUN);
  assign busy           = (r_state != S_IDLE) && (r_state != S_RUN);
  assign words_loaded   = r_words;
  assign mismatch_count = r_mism_cnt;
  assign mismatch_addr  = r_mism_addr;

endmodule

// File: tb/tb_panel_image_loader.sv
// Bench for panel_image_loader: directed and random images against a press-event model and a panel emulator.
module tb_panel_image_loader;
  import panel_image_loader_pkg::*;

  localparam int AW = 12, DW = 12, HOLD = 2, SETTLE = 3, DEPTH = 8, CW = 16;

  logic clock = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  panel_image_loader_if #(.ADDR_W(AW), .DATA_W(DW)) img();

  logic          verify_en;
  logic [AW-1:0] start_pc;
  logic [DW-1:0] panel_data;
  logic [DW-1:0] sw_out;
  logic          load_pc_btn, deposit_btn, examine_btn, run_sw, busy, load_done;
  logic [CW-1:0] words_loaded;
  logic [7:0]    mismatch_count;
  logic [AW-1:0] mismatch_addr;

  panel_image_loader #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH),
    .HOLD_CYCLES(HOLD), .SETTLE_CYCLES(SETTLE), .CNT_W(CW)
  ) dut (
    .clock(clock), .resetN(resetN), .img(img), .verify_en(verify_en),
    .start_pc(start_pc), .panel_data(panel_data), .sw_out(sw_out),
    .load_pc_btn(load_pc_btn), .deposit_btn(deposit_btn), .examine_btn(examine_btn),
    .run_sw(run_sw), .busy(busy), .load_done(load_done), .words_loaded(words_loaded),
    .mismatch_count(mismatch_count), .mismatch_addr(mismatch_addr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o, expected %0o (octal)", name, act, exp);
    end
  endtask

  typedef struct {
    panel_btn_t    btn;
    logic [DW-1:0] sw;
  } press_t;
  press_t exp_q[$];

  // Panel emulator: PC register, memory and examine display.
  logic [AW-1:0] pc, ex_addr, force_addr;
  logic [DW-1:0] pmem [4096];
  logic [DW-1:0] disp;
  bit            force_en;
  assign panel_data = (force_en && ex_addr == force_addr) ? '0 : disp;

  logic [DW-1:0] prev_sw;
  logic [2:0]    prev_b;
  int            stable, hi_cnt;
  int            cnt_lpc, cnt_dep, cnt_exm;
  bit            saw_stall;

  always @(negedge clock) begin
    logic [2:0] b;
    press_t     e;
    b = {examine_btn, deposit_btn, load_pc_btn};
    if (!resetN) begin
      prev_sw = '0; prev_b = '0; stable = 0; hi_cnt = 0;
    end else begin
      check_eq("one_button_high", 64'($countones(b) <= 1), 1);
      if (b != prev_b) check_eq("sw_steady_on_button_edge", sw_out, prev_sw);
      if (b != 3'b000 && prev_b == 3'b000) begin
        check_eq("sw_setup_cycles", 64'(stable >= HOLD), 1);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_press", b, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("press_button", b, 3'b001 << e.btn);
          check_eq("press_value", sw_out, e.sw);
        end
        if (load_pc_btn) begin cnt_lpc++; pc = sw_out; end
        if (deposit_btn) begin cnt_dep++; pmem[pc] = sw_out; pc = pc + 1'b1; end
        if (examine_btn) begin cnt_exm++; ex_addr = pc; disp = pmem[pc]; pc = pc + 1'b1; end
      end
      if (b != 3'b000) hi_cnt++;
      if (b == 3'b000 && prev_b != 3'b000) begin
        check_eq("press_width", hi_cnt, HOLD);
        hi_cnt = 0;
      end
      stable  = (sw_out == prev_sw) ? stable + 1 : 1;
      prev_sw = sw_out;
      prev_b  = b;
    end
  end

  // Expected press sequence derived directly from the image word list.
  function automatic void build_model(input image_word_t ws[$], input bit vfy, input logic [AW-1:0] spc,
                                      input bit fen, input logic [AW-1:0] faddr,
                                      output int mm, output logic [AW-1:0] mm_addr);
    logic [AW-1:0] ea;
    bit            ev;
    ev = 1'b0; ea = '0; mm = 0; mm_addr = '0;
    exp_q.delete();
    foreach (ws[i]) begin
      if (!(ev && ws[i].addr == ea)) exp_q.push_back('{BTN_LPC, ws[i].addr});
      exp_q.push_back('{BTN_DEP, ws[i].data});
      if (vfy) begin
        exp_q.push_back('{BTN_LPC, ws[i].addr});
        exp_q.push_back('{BTN_EXM, ws[i].addr});
        if (fen && ws[i].addr == faddr && ws[i].data != '0) begin
          if (mm == 0) mm_addr = ws[i].addr;
          mm++;
        end
      end
      ea = ws[i].addr + 1'b1;
      ev = 1'b1;
    end
    exp_q.push_back('{BTN_LPC, spc});
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    img.in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #3 resetN = 1'b1;
    tick();
  endtask

  task automatic push_words(input image_word_t ws[$], input int gap_max);
    int guard;
    bit rdy;
    foreach (ws[i]) begin
      img.in_valid = 1'b1;
      img.in_addr  = ws[i].addr;
      img.in_data  = ws[i].data;
      img.in_last  = ws[i].last;
      guard = 0;
      forever begin
        rdy = img.in_ready;
        tick();
        if (rdy) break;
        saw_stall = 1'b1;
        guard++;
        if (guard > 5000) begin
          check_eq("push_timeout", 0, 1);
          img.in_valid = 1'b0;
          return;
        end
      end
      img.in_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic run_image(input string tag, input image_word_t ws[$], input bit vfy,
                           input logic [AW-1:0] spc, input bit fen, input logic [AW-1:0] faddr,
                           input int gap_max, input bit rst);
    int            mm, guard;
    logic [AW-1:0] mm_addr;
    if (rst) do_reset();
    verify_en = vfy; start_pc = spc; force_en = fen; force_addr = faddr;
    cnt_lpc = 0; cnt_dep = 0; cnt_exm = 0; saw_stall = 1'b0;
    pc = '0; ex_addr = '0; disp = '0;
    build_model(ws, vfy, spc, fen, faddr, mm, mm_addr);
    check_eq({tag, "_reset_outputs"}, {sw_out, load_pc_btn, deposit_btn, examine_btn, run_sw, busy,
             load_done, words_loaded, mismatch_count, mismatch_addr}, 0);
    check_eq({tag, "_reset_in_ready"}, img.in_ready, 1);
    push_words(ws, gap_max);
    guard = 0;
    while (!load_done && guard < 20000) begin tick(); guard++; end
    check_eq({tag, "_load_done"}, load_done, 1);
    check_eq({tag, "_presses_left"}, exp_q.size(), 0);
    check_eq({tag, "_words_loaded"}, words_loaded, CW'(ws.size()));
    check_eq({tag, "_mismatch_count"}, mismatch_count, (mm > 255) ? 255 : mm);
    check_eq({tag, "_mismatch_addr"}, mismatch_addr, mm_addr);
    check_eq({tag, "_run_state"}, {run_sw, busy, sw_out, img.in_ready}, {1'b1, 1'b0, 12'o0, 1'b0});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    image_word_t   q[$];
    image_word_t   w;
    logic [AW-1:0] a;
    bit            vfy, fen;
    int            n, guard;

    for (int i = 0; i < 4096; i++) pmem[i] = '0;
    verify_en = 1'b0; start_pc = DEFAULT_START_PC; force_en = 1'b0; force_addr = '0;
    img.in_valid = 1'b0; img.in_addr = '0; img.in_data = '0; img.in_last = 1'b0;
    pc = '0; ex_addr = '0; disp = '0;

    q = {};
    q.push_back('{1'b0, 12'o0200, 12'o7300});
    q.push_back('{1'b0, 12'o0201, 12'o1205});
    q.push_back('{1'b1, 12'o0202, 12'o7402});
    run_image("contig", q, 1'b0, DEFAULT_START_PC, 1'b0, '0, 2, 1'b1);
    check_eq("contig_lpc_pulses", cnt_lpc, 2);
    check_eq("contig_dep_pulses", cnt_dep, 3);
    check_eq("contig_words_loaded", words_loaded, 3);

    q = {};
    q.push_back('{1'b0, 12'o0010, 12'o1111});
    q.push_back('{1'b1, 12'o0400, 12'o2222});
    run_image("noncontig", q, 1'b0, DEFAULT_START_PC, 1'b0, '0, 2, 1'b1);
    check_eq("noncontig_lpc_pulses", cnt_lpc, 3);

    q = {};
    q.push_back('{1'b0, 12'o7777, 12'o0001});
    q.push_back('{1'b1, 12'o0000, 12'o0002});
    run_image("wrap", q, 1'b0, DEFAULT_START_PC, 1'b0, '0, 2, 1'b1);
    check_eq("wrap_lpc_pulses", cnt_lpc, 2);
    check_eq("wrap_pmem_0000", pmem[0], 12'o0002);

    q = {};
    q.push_back('{1'b0, 12'o0300, 12'o1234});
    q.push_back('{1'b0, 12'o0301, 12'o4321});
    q.push_back('{1'b1, 12'o0302, 12'o5555});
    run_image("verify", q, 1'b1, DEFAULT_START_PC, 1'b1, 12'o0301, 1, 1'b1);
    check_eq("verify_mismatch_count", mismatch_count, 1);
    check_eq("verify_mismatch_addr", mismatch_addr, 12'o0301);
    check_eq("verify_exm_pulses", cnt_exm, 3);

    q = {};
    for (int i = 0; i < 12; i++) begin
      w.last = (i == 11); w.addr = 12'o0100 + 12'(i); w.data = 12'(i * 37 + 5);
      q.push_back(w);
    end
    run_image("backpressure", q, 1'b0, DEFAULT_START_PC, 1'b0, '0, 0, 1'b1);
    check_eq("backpressure_saw_not_ready", saw_stall, 1);
    check_eq("backpressure_dep_pulses", cnt_dep, 12);

    q = {};
    q.push_back('{1'b0, 12'o0500, 12'o1111});
    q.push_back('{1'b0, 12'o0501, 12'o2222});
    q.push_back('{1'b1, 12'o0502, 12'o3333});
    do_reset();
    verify_en = 1'b0; force_en = 1'b0;
    begin
      int            mm;
      logic [AW-1:0] mm_addr;
      build_model(q, 1'b0, DEFAULT_START_PC, 1'b0, '0, mm, mm_addr);
    end
    push_words(q, 0);
    guard = 0;
    while (!deposit_btn && guard < 2000) begin tick(); guard++; end
    check_eq("midreset_reached_deposit", deposit_btn, 1);
    #2 resetN = 1'b0;
    #1;
    check_eq("midreset_deposit_dropped", deposit_btn, 0);
    check_eq("midreset_outputs_zero", {sw_out, load_pc_btn, examine_btn, run_sw, busy, load_done,
             words_loaded, mismatch_count, mismatch_addr}, 0);
    exp_q.delete();
    @(posedge clock);
    #3 resetN = 1'b1;
    repeat (20) tick();
    check_eq("midreset_fifo_empty_idle", {busy, words_loaded, img.in_ready}, {1'b0, 16'd0, 1'b1});
    run_image("reload", q, 1'b0, DEFAULT_START_PC, 1'b0, '0, 1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      q = {};
      n = $urandom_range(1, 10);
      a = 12'($urandom);
      for (int i = 0; i < n; i++) begin
        if (i > 0) a = ($urandom_range(0, 9) < 7) ? a + 1'b1 : 12'($urandom);
        w.last = (i == n - 1); w.addr = a; w.data = 12'($urandom);
        q.push_back(w);
      end
      vfy = 1'($urandom_range(0, 1));
      fen = vfy && ($urandom_range(0, 1) == 1);
      run_image($sformatf("random%0d", t), q, vfy, 12'($urandom), fen,
                q[$urandom_range(0, n - 1)].addr, 3, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/panel_image_loader.md
Name: panel_image_loader

Overview:
- Synthesizable successor to the bench-side Load_PC/Deposit front-panel tasks.
- Accepts a stream of {address, data, last} memory-image words through a small FIFO and drives the Front_Panel switch and button inputs with programmable hold timing.
- Skips redundant Load PC presses on contiguous addresses, optionally read-back-verifies each deposit via Examine, then loads the start PC and raises the run switch.
- Sits between the image source (DPI transactor or ROM streamer) and Front_Panel.

Parameters:
- ADDR_W, 12: image address width.
- DATA_W, 12: image data width; also the panel switch width.
- FIFO_DEPTH, 8: inbound word buffer depth, power of two, minimum 2.
- HOLD_CYCLES, 10: clocks per press phase (setup, press, release).
- SETTLE_CYCLES, 30: idle clocks after each deposit or examine.
- CNT_W, 16: width of words_loaded.

Ports:
- clock  in  1  system clock.
- resetN  in  1  Reset. Asynchronous, active-low.
- in_valid  in  1  image word valid.
- in_ready  out  1  FIFO can accept a word.
- in_addr  in  ADDR_W  word address.
- in_data  in  DATA_W  word data.
- in_last  in  1  final image word.
- verify_en  in  1  enables read-back verify; sampled when a word is popped.
- start_pc  in  ADDR_W  PC loaded before run.
- panel_data  in  DATA_W  Front_Panel examine/display data.
- sw_out  out  DATA_W  panel switches [DATA_W-1:0].
- load_pc_btn  out  1  Load PC button.
- deposit_btn  out  1  Deposit button.
- examine_btn  out  1  Examine button.
- run_sw  out  1  run switch (sw[12]).
- busy  out  1  FSM not in IDLE or RUN.
- load_done  out  1  image loaded and start PC set.
- words_loaded  out  CNT_W  deposits completed, wraps.
- mismatch_count  out  8  verify failures, saturates at 255.
- mismatch_addr  out  ADDR_W  address of the first mismatch.

Behaviour:
- Reset: all outputs 0, FIFO empty, expected-address register invalid. Asynchronous assertion drops all buttons immediately. Reset mid-press aborts with no residual press.
- FIFO: in_ready = !full && !last_seen.
  - Push on in_valid && in_ready. Pushing while full is impossible.
  - Once a word with in_last is accepted, last_seen is set and in_ready stays 0 until reset.
- Press primitive (sub-module): three phases of HOLD_CYCLES each.
  - SET: sw_out = value, button low.
  - PRESS: button high.
  - REL: button low.
  - sw_out holds its value until the next SET.
- FSM states: IDLE, POP, LPC, DEP, EXM, SETTLE, CHECK, START_LPC, RUN.
- IDLE: if FIFO not empty, go to POP. If FIFO empty and last processed, go to START_LPC.
- POP: dequeue; latch addr, data, last, verify_en.
  - If exp_valid && addr == exp_addr, go to DEP.
  - Otherwise go to LPC with value = addr.
- LPC: press load_pc_btn, then go to DEP.
- DEP: press deposit_btn with value = data.
  - exp_addr = addr + 1 mod 2^ADDR_W (7777 wraps to 0000); exp_valid = 1.
  - words_loaded += 1 at the end of REL.
  - Go to SETTLE.
- SETTLE: wait SETTLE_CYCLES.
  - If verify is pending, go to EXM-prep.
  - Otherwise go to IDLE, or to START_LPC if last.
- Verify sequence: press load_pc_btn with addr, then examine_btn, then SETTLE, then CHECK.
  - Examine advances the panel PC, so exp_addr = addr + 1 again.
- CHECK: sample panel_data in one cycle.
  - On inequality: mismatch_count++ (saturating). mismatch_addr is captured only when the count was 0.
  - Then go to IDLE, or to START_LPC if last.
- START_LPC: press load_pc_btn with start_pc; exp_valid = 0.
- RUN: load_done = 1, run_sw = 1, sw_out[DATA_W-1:0] = 0. Terminal state until reset.
- Empty FIFO mid-image without last: stay in IDLE, buttons low, busy = 0.
- Zero-word image (first word is last): performs a normal deposit. There is no "empty image" encoding.
- Only one button is ever high at a time. Buttons never change in the same cycle as sw_out.

Decomposition:
- Shared package adds:
  - loader_state_t enum.
  - panel_btn_t enum {BTN_LPC, BTN_DEP, BTN_EXM}.
  - image_word_t struct {last, addr, data}.
  - Default constants DEFAULT_START_PC = 12'o0200, HOLD_CYCLES, SETTLE_CYCLES.
- Sub-module panel_press_seq:
  - Inputs: req, btn select, value.
  - Outputs: sw value, three button lines, done pulse.
  - Internal phase counter of $clog2(HOLD_CYCLES+1) bits.
- FIFO is inline.

Test Plan (HOLD_CYCLES=2, SETTLE_CYCLES=3, start_pc=0200):
- Contiguous image 0200:7300, 0201:1205, 0202:7402(last) -> exactly 2 load_pc_btn pulses (0200, then start 0200), 3 deposit pulses, words_loaded=3, run_sw=1.
- Non-contiguous image 0010:1111, 0400:2222(last) -> 3 Load PC pulses (0010, 0400, 0200), each 2 cycles wide, each preceded by 2 cycles of stable sw_out.
- Wrap: 7777:0001, 0000:0002(last) -> single Load PC before data, exp_addr wraps, no Load PC for 0000.
- Verify with panel_data forced to 0000 on the 2nd word of 3 -> mismatch_count=1, mismatch_addr = 2nd address, load still completes.
- FIFO backpressure: source pushes 12 words back-to-back with depth 8 -> in_ready low when full, no word lost or duplicated, deposit order preserved.
- resetN low during DEP PRESS -> deposit_btn falls asynchronously, all outputs 0, FIFO empty; reload succeeds afterwards.
